// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter that shares one NoC output link among the E, W and L input FIFOs.
// Multi-flit packets keep the link until their tail flit, so packets never interleave.
module noc_port_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       tail,
  input  logic [WIDTH-1:0] dataIn0,
  input  logic [WIDTH-1:0] dataIn1,
  input  logic [WIDTH-1:0] dataIn2,
  input  logic             destFull,
  input  logic             destAlmostFull,
  output logic [2:0]       pop,
  output logic             writeOut,
  output logic [WIDTH-1:0] dataOut,
  output logic [2:0]       grant,
  output logic             busy
);

  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  logic             state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       owner_reg, owner_next;
  logic             write_reg;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [2:0]       grant_reg;
  logic             ok;
  logic             issue;
  logic [1:0]       win;
  logic [1:0]       idx [3];

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // An almost-full destination accepts at most one flit in flight at a time.
  assign ok = !destFull && !(destAlmostFull && write_reg);

  assign idx[0] = ptr_reg;
  assign idx[1] = inc3(ptr_reg);
  assign idx[2] = inc3(idx[1]);

  always_comb begin
    issue      = 1'b0;
    win        = 2'd0;
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    if (ok) begin
      if (state_reg == IDLE) begin
        // Walk the scan order backwards so the earliest requester is the last one written.
        for (int i = 2; i >= 0; i--) begin
          if (req[idx[i]]) begin
            issue = 1'b1;
            win   = idx[i];
          end
        end
        if (issue) begin
          ptr_next = inc3(win);
          if (!tail[win]) begin
            owner_next = win;
            state_next = LOCKED;
          end
        end
      end else if (req[owner_reg]) begin
        issue = 1'b1;
        win   = owner_reg;
        if (tail[owner_reg]) state_next = IDLE;
      end
    end
  end

  always_comb begin
    case (win)
      2'd1:    data_next = dataIn1;
      2'd2:    data_next = dataIn2;
      default: data_next = dataIn0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pop
      assign pop[gi] = reset && issue && (win == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      owner_reg <= 2'd0;
      write_reg <= 1'b0;
      data_reg  <= '0;
      grant_reg <= 3'b000;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      write_reg <= issue;
      grant_reg <= pop;
      if (issue) data_reg <= data_next;
    end
  end

  assign writeOut = write_reg;
  assign dataOut  = data_reg;
  assign grant    = grant_reg;
  assign busy     = (state_reg == LOCKED);

endmodule

// File: doc/noc_port_arbiter.md
# noc_port_arbiter

Round-robin output-port arbiter for one NoC router output link. Shares a single destination write port among the router's three input FIFOs (E, W, L), pops the winning FIFO head, registers the flit onto the link, and respects the destination's full/almost_full backpressure. Multi-flit packets hold the grant until their tail flit, so packets are never interleaved on the link.

## Interface
- WIDTH, 16, flit data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  3  FIFO non-empty per requester; bit 0=E, 1=W, 2=L
- tail  in  3  head flit of requester i is a packet tail; only meaningful while req[i]=1
- dataIn0 / dataIn1 / dataIn2  in  WIDTH each  head flit of E / W / L FIFO
- destFull  in  1  destination FIFO full
- destAlmostFull  in  1  destination FIFO almost full
- pop  out  3  one-hot combinational read strobe to the winning FIFO
- writeOut  out  1  registered write strobe to the destination
- dataOut  out  WIDTH  registered flit to the destination
- grant  out  3  registered one-hot source of the flit on dataOut; 0 when writeOut=0
- busy  out  1  registered; 1 while in LOCKED state

## Operation
- Issue-enable: ok = !destFull && !(destAlmostFull && writeOut).
- State: IDLE, LOCKED. Registers: ptr (2 bits, 0..2), owner (2 bits).
- IDLE: if ok and req!=0, winner w = first requesting index scanning ptr, ptr+1, ptr+2 (mod 3).
  - pop[w]=1 this cycle; next edge: dataOut<=dataIn[w], writeOut<=1, grant<=one-hot(w), ptr<=(w+1) mod 3.
  - if tail[w]=0: owner<=w, go to LOCKED (busy<=1); otherwise stay IDLE.
- LOCKED: only owner is eligible; other requests are ignored and ptr is frozen.
  - if ok and req[owner]: pop[owner]=1, flit registered as above; if tail[owner]=1, go to IDLE (busy<=0).
  - if !req[owner] or !ok: wait in LOCKED, no pop.
- No issue in a cycle: next edge writeOut<=0, grant<=0, dataOut holds its value.
- pop is at most one-hot; pop=0 whenever reset is asserted, ok=0, or no eligible request.
- ptr wraps 2->0; value 3 is never reached.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, ptr=0, owner=0, writeOut=0, dataOut=0, grant=0, busy=0, pop=0.
- Reset mid-packet drops the lock; after release, arbitration restarts from ptr=0.
- Latency: pop at cycle N -> writeOut/dataOut/grant valid at cycle N+1.
- Throughput: 1 flit/cycle while destAlmostFull=0. While destAlmostFull=1, at most one write every two cycles, so at most one flit is ever in flight into an almost-full destination.
- destFull rising at cycle N: pop=0 in cycle N; writeOut=0 from N+1. A flit already registered at N is still written; the destination's almost_full margin absorbs it.
- Simultaneous requests: round-robin as above. Grants never interleave within a packet.
- A requester that drops req mid-packet stalls the link in LOCKED. No timeout; this is intended.

## Test plan
- Reset: drive reset=0 with random inputs -> pop=0, writeOut=0, dataOut=0, grant=0, busy=0. After release with req=0 and no traffic, outputs stay 0.
- Fairness: req=3'b111, tail=3'b111, dataIn0/1/2 = 16'h000A/16'h000B/16'h000C, dest free for 6 cycles -> pop sequence 001, 010, 100, 001, 010, 100. writeOut=1 continuously from cycle 2. dataOut = A, B, C, A, B, C, each one cycle after its pop.
- Packet lock: all three request. W head has tail=0 for 2 flits, then tail=1; ptr=1 at start -> W popped 3 consecutive cycles. busy=1 from the cycle after W's first pop through W's tail pop, then 0. Next grant goes to L (ptr=2), then E.
- Almost full: req=3'b001, tail=1, destAlmostFull=1 held for 8 cycles -> pop[0] on alternate cycles (4 pops), and writeOut toggles 1,0,1,0.
- Full stall: streaming req=3'b010; assert destFull at cycle 5 for 3 cycles -> pop=0 in cycles 5-7. writeOut=1 at cycle 5 (flit popped at cycle 4), then 0 in cycles 6-8. Pops resume at cycle 8 with no flit lost or duplicated.
- Reset mid-packet: E is in LOCKED after a tail=0 flit; assert reset for 1 cycle -> busy=0 and writeOut=0 immediately. After release with req=3'b110, W wins first (ptr=0 scan skips E).
